// File: rtl/display_scan_controller_pkg.sv
// rtl/display_scan_controller_pkg.sv - shared constants and types for the multiplexed display scanner
package display_scan_controller_pkg;

    localparam int         MAX_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/display_scan_controller_seven_segment.sv
// rtl/display_scan_controller_seven_segment.sv - hex nibble to active-low {a..g} segment decoder, a at MSB
module display_scan_controller_seven_segment (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h01;
            4'h1: seg = 7'h4F;
            4'h2: seg = 7'h12;
            4'h3: seg = 7'h06;
            4'h4: seg = 7'h4C;
            4'h5: seg = 7'h24;
            4'h6: seg = 7'h20;
            4'h7: seg = 7'h0F;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h04;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h60;
            4'hC: seg = 7'h31;
            4'hD: seg = 7'h42;
            4'hE: seg = 7'h30;
            4'hF: seg = 7'h38;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - time-multiplexed hex display scanner with frame-aligned value commit
// Optional build macro LEADING_ZERO_SUPPRESS_EN darkens leading zero digits above digit 0.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    output logic                    load_ack,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out
);

    localparam int              CW       = $clog2(REFRESH_DIV);
    localparam int              W        = 4 * NUM_DIGITS;
    localparam logic [CW-1:0]   CNT_MAX  = CW'(REFRESH_DIV - 1);
    localparam digit_idx_t      LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

    logic [CW-1:0]         cnt;
    digit_idx_t            idx;
    digit_idx_t            idx_nxt;
    logic [W-1:0]          disp;
    logic [W-1:0]          disp_nxt;
    logic [W-1:0]          pend;
    logic                  pending;
    logic                  primed;
    logic                  tick;
    logic                  commit;
    logic [3:0]            nibble;
    logic [6:0]            seg_dec;
    logic [NUM_DIGITS-1:0] an_sel;
    logic                  dark;

    assign tick   = (cnt == CNT_MAX);
    assign commit = tick && (idx == LAST_IDX);

    always_comb begin
        idx_nxt = idx;
        if (tick) idx_nxt = (idx == LAST_IDX) ? digit_idx_t'(0) : idx + digit_idx_t'(1);
    end

    // A load arriving on the commit edge wins over any older pending value.
    always_comb begin
        disp_nxt = disp;
        if (commit) begin
            if (load)         disp_nxt = value_in;
            else if (pending) disp_nxt = pend;
        end
    end

    always_comb begin
        nibble = '0;
        an_sel = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_nxt == digit_idx_t'(k)) begin
                nibble    = disp_nxt[4*k +: 4];
                an_sel[k] = 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_SUPPRESS_EN
    logic lz_dark;

    always_comb begin
        lz_dark = 1'b0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (idx_nxt == digit_idx_t'(k)) lz_dark = ((disp_nxt >> (4*k)) == '0);
        end
    end

    assign dark = (|(blank_mask & ~an_sel)) || lz_dark;
`else
    assign dark = |(blank_mask & ~an_sel);
`endif

    display_scan_controller_seven_segment u_seven_segment (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt      <= '0;
            idx      <= '0;
            disp     <= '0;
            pend     <= '0;
            pending  <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            cnt      <= tick ? '0 : cnt + CW'(1);
            idx      <= idx_nxt;
            disp     <= disp_nxt;
            load_ack <= commit && (load || pending);
            if (commit) begin
                pending <= 1'b0;
            end else if (load) begin
                pend    <= value_in;
                pending <= 1'b1;
            end
        end
    end

    // Outputs load on the first edge after reset and then only at slot starts,
    // so blank_mask is sampled once per slot and seg/an never skew.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            primed  <= 1'b0;
            an_out  <= '1;
            seg_out <= SEG_BLANK;
        end else begin
            primed <= 1'b1;
            if (!primed || tick) begin
                an_out  <= dark ? '1 : an_sel;
                seg_out <= dark ? SEG_BLANK : seg_dec;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - directed self-checking bench for display_scan_controller
module tb_display_scan_controller;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [31:0] value_in = '0;
    logic        load = 1'b0;
    logic        load_ack;
    logic [7:0]  blank_mask = '0;
    logic [6:0]  seg_out;
    logic [7:0]  an_out;

    int checks = 0;
    int errors = 0;
    int ecount = 0;
    int acks = 0;
    bit prev_ack = 1'b0;
    bit consec = 1'b0;
    int b, b2, a0;

`ifdef LEADING_ZERO_SUPPRESS_EN
    localparam bit LZS = 1'b1;
`else
    localparam bit LZS = 1'b0;
`endif

    display_scan_controller #(.REFRESH_DIV(4), .NUM_DIGITS(8)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .value_in   (value_in),
        .load       (load),
        .load_ack   (load_ack),
        .blank_mask (blank_mask),
        .seg_out    (seg_out),
        .an_out     (an_out)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) ecount <= ecount + 1;

    always @(negedge Clk) begin
        if (load_ack) acks = acks + 1;
        if (load_ack && prev_ack) consec = 1'b1;
        prev_ack = load_ack;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic at_edge(input int e);
        while (ecount < e) @(negedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic slot(input string tag, input int e, input int k, input logic [6:0] seg_exp, input bit lit);
        logic [7:0] an_exp;
        at_edge(e);
        an_exp = 8'hFF;
        if (lit) an_exp[k] = 1'b0;
        chk({tag, "_an"}, {24'h0, an_out}, {24'h0, an_exp});
        chk({tag, "_seg"}, {25'h0, seg_out}, {25'h0, (lit ? seg_exp : 7'h7F)});
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_an", {24'h0, an_out}, 32'hFF);
        chk("rst_seg", {25'h0, seg_out}, 32'h7F);
        chk("rst_ack", {31'h0, load_ack}, 32'h0);
        Rst_n = 1'b1;
        b = ecount;

        // frame 0: all digits show zero
        for (int k = 0; k < 8; k++) slot("f0", b + 4*k + 1, k, 7'h01, !LZS || k == 0);

        // single load in slot 2, committed at the frame boundary
        at_edge(b + 40); value_in = 32'h0000_00A5; load = 1'b1;
        at_edge(b + 41); load = 1'b0; a0 = acks;
        slot("pre_commit", b + 61, 7, 7'h01, !LZS);
        chk("ack_before_commit", {31'h0, load_ack}, 32'h0);
        at_edge(b + 64);
        chk("ack_at_commit", {31'h0, load_ack}, 32'h1);
        slot("a5_d0", b + 64, 0, 7'h24, 1'b1);
        at_edge(b + 65);
        chk("ack_after_commit", {31'h0, load_ack}, 32'h0);
        chk("ack_count_single", acks - a0, 32'd1);
        slot("a5_d1", b + 69, 1, 7'h08, 1'b1);
        slot("a5_d2", b + 73, 2, 7'h01, !LZS);

        // two loads in one frame merge into one acknowledge
        at_edge(b + 73); value_in = 32'h1; load = 1'b1;
        at_edge(b + 74); load = 1'b0;
        at_edge(b + 81); value_in = 32'h2; load = 1'b1;
        at_edge(b + 82); load = 1'b0; a0 = acks;
        at_edge(b + 95);
        chk("merge_no_early_ack", acks - a0, 32'd0);
        at_edge(b + 97);
        chk("merge_ack_count", acks - a0, 32'd1);
        slot("merge_d0", b + 97, 0, 7'h12, 1'b1);
        slot("merge_d1", b + 101, 1, 7'h01, !LZS);

        // load on the commit edge bypasses pending
        at_edge(b + 127); value_in = 32'h1234_5677; load = 1'b1; a0 = acks;
        at_edge(b + 128); load = 1'b0;
        chk("bypass_ack", {31'h0, load_ack}, 32'h1);
        slot("bypass_d0", b + 128, 0, 7'h0F, 1'b1);
        at_edge(b + 131);
        chk("bypass_ack_count", acks - a0, 32'd1);
        slot("bypass_d3", b + 141, 3, 7'h24, 1'b1);
        slot("bypass_d7", b + 157, 7, 7'h4F, 1'b1);

        // blank_mask darkens only its slot; mid-slot changes wait for the next slot start
        at_edge(b + 160); blank_mask = 8'h02;
        slot("blank_d0", b + 161, 0, 7'h0F, 1'b1);
        slot("blank_d1", b + 165, 1, 7'h0F, 1'b0);
        slot("blank_d2", b + 169, 2, 7'h20, 1'b1);
        at_edge(b + 170); blank_mask = 8'h06;
        slot("blank_midslot_d2", b + 171, 2, 7'h20, 1'b1);
        slot("blank_d3", b + 173, 3, 7'h24, 1'b1);
        at_edge(b + 190); blank_mask = 8'h00;

        // reset with a pending load discards it
        at_edge(b + 193); value_in = 32'hFFFF_FFFF; load = 1'b1;
        at_edge(b + 194); load = 1'b0;
        at_edge(b + 200); Rst_n = 1'b0; a0 = acks;
        at_edge(b + 202);
        chk("rst2_an", {24'h0, an_out}, 32'hFF);
        chk("rst2_seg", {25'h0, seg_out}, 32'h7F);
        chk("rst2_ack", {31'h0, load_ack}, 32'h0);
        Rst_n = 1'b1;
        b2 = ecount;
        slot("rst2_d0", b2 + 1, 0, 7'h01, 1'b1);
        slot("rst2_d1", b2 + 5, 1, 7'h01, !LZS);
        at_edge(b2 + 33);
        chk("rst2_no_ack", acks - a0, 32'd0);
        slot("rst2_next_frame_d0", b2 + 33, 0, 7'h01, 1'b1);

        chk("ack_never_consecutive", {31'h0, consec}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
